// File: rtl/prt_scaler_hds.sv
// Horizontal 2:1 down scaler. Two consecutive input words (A then B) are
// reduced to one output word: each output pixel is the truncated average of
// an adjacent pixel pair, the low half of the output from A and the high half
// from B. A short phase FSM pairs the words, an HS rising edge restarts
// pairing, and a two-stage pipeline produces DAT_OUT/DE_OUT.
module prt_scaler_hds #(
  parameter int P_PPC = 4,
  parameter int P_BPC = 8
) (
  input  logic                     CLK_IN,
  input  logic                     RST_IN,
  input  logic                     CTL_RUN_IN,
  input  logic                     HS_IN,
  input  logic [P_PPC*P_BPC-1:0]   DAT_IN,
  input  logic                     WR_IN,
  output logic                     HS_OUT,
  output logic [P_PPC*P_BPC-1:0]   DAT_OUT,
  output logic                     DE_OUT
);

  localparam int W    = P_PPC * P_BPC;
  localparam int HALF = P_PPC / 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PH_A = 2'd1,
    ST_PH_B = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   cap_a;      // current input word becomes word A
  logic   issue;      // current input word is word B: launch the pair

  logic         hs_d1_q;   // HS_IN one cycle late; doubles as edge-detect history
  logic         hs_out_q;
  logic         hs_edge;
  logic [W-1:0] a_q;

  logic [P_PPC-1:0][P_BPC:0] sum_d;
  logic [P_PPC-1:0][P_BPC:0] sum_q;
  logic                      s1_vld_q;
  logic [W-1:0]              avg_d;
  logic [W-1:0]              dat_q;
  logic                      de_q;

  assign hs_edge = HS_IN & ~hs_d1_q;

  // Next phase and capture strobes; a line-start edge always restarts at word A.
  always_comb begin
    state_d = state_q;
    cap_a   = 1'b0;
    issue   = 1'b0;
    if (!CTL_RUN_IN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_PH_A;
        ST_PH_A: begin
          if (WR_IN) begin
            cap_a   = 1'b1;
            state_d = ST_PH_B;
          end
        end
        ST_PH_B: begin
          if (hs_edge) begin
            // held word A is dropped; a coincident word starts the new line
            if (WR_IN) begin
              cap_a   = 1'b1;
              state_d = ST_PH_B;
            end else begin
              state_d = ST_PH_A;
            end
          end else if (WR_IN) begin
            issue   = 1'b1;
            state_d = ST_PH_A;
          end
        end
        default: state_d = ST_PH_A;
      endcase
    end
  end

  // Phase register and word-A holding register.
  always_ff @(posedge CLK_IN) begin
    if (!RST_IN) begin
      state_q <= ST_PH_A;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      if (cap_a) a_q <= DAT_IN;
    end
  end

  // Pair sums: low half of the output from word A, high half from word B (live input).
  generate
    for (genvar gi = 0; gi < P_PPC; gi++) begin : g_sum
      if (gi < HALF) begin : g_from_a
        assign sum_d[gi] = {1'b0, a_q[(2*gi)*P_BPC +: P_BPC]}
                         + {1'b0, a_q[(2*gi+1)*P_BPC +: P_BPC]};
      end else begin : g_from_b
        assign sum_d[gi] = {1'b0, DAT_IN[(2*gi-P_PPC)*P_BPC +: P_BPC]}
                         + {1'b0, DAT_IN[(2*gi-P_PPC+1)*P_BPC +: P_BPC]};
      end
      // halve by dropping the sum LSB (truncation, never overflows)
      assign avg_d[gi*P_BPC +: P_BPC] = P_BPC'(sum_q[gi] >> 1);
    end
  endgenerate

  // Stage 1: register the pair sums on the word-B cycle.
  always_ff @(posedge CLK_IN) begin
    if (!RST_IN) begin
      sum_q    <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= issue;
      if (issue) sum_q <= sum_d;
    end
  end

  // Stage 2: output word and one-cycle enable; data holds between pulses.
  always_ff @(posedge CLK_IN) begin
    if (!RST_IN) begin
      dat_q <= '0;
      de_q  <= 1'b0;
    end else begin
      de_q <= s1_vld_q;
      if (s1_vld_q) dat_q <= avg_d;
    end
  end

  // HS delay line matching the two-stage data latency; runs regardless of CTL_RUN_IN.
  always_ff @(posedge CLK_IN) begin
    if (!RST_IN) begin
      hs_d1_q  <= 1'b0;
      hs_out_q <= 1'b0;
    end else begin
      hs_d1_q  <= HS_IN;
      hs_out_q <= hs_d1_q;
    end
  end

  assign HS_OUT  = hs_out_q;
  assign DAT_OUT = dat_q;
  assign DE_OUT  = de_q;

endmodule

// File: tb/tb_prt_scaler_hds.sv
// Bench for prt_scaler_hds: expected words are queued when word B is driven,
// and popped when DE_OUT fires (with the cycle it is due).
module tb_prt_scaler_hds;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b1;
  logic        hs_in = 1'b0;
  logic [31:0] dat_in = '0;
  logic        wr_in = 1'b0;
  logic        hs_out;
  logic [31:0] dat_out;
  logic        de_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] dat;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  prt_scaler_hds #(.P_PPC(4), .P_BPC(8)) dut (
    .CLK_IN    (clk),
    .RST_IN    (rst_n),
    .CTL_RUN_IN(run),
    .HS_IN     (hs_in),
    .DAT_IN    (dat_in),
    .WR_IN     (wr_in),
    .HS_OUT    (hs_out),
    .DAT_OUT   (dat_out),
    .DE_OUT    (de_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference average: out pixel j from adjacent pair of A (j<2) or B (j>=2).
  function automatic logic [31:0] avg_word(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic [8:0]  s;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      if (j < 2) s = {1'b0, a[16*j +: 8]} + {1'b0, a[16*j+8 +: 8]};
      else       s = {1'b0, b[16*(j-2) +: 8]} + {1'b0, b[16*(j-2)+8 +: 8]};
      r[8*j +: 8] = s[8:1];
    end
    return r;
  endfunction

  // Call just before driving word B: output is due two clock edges later.
  task automatic push_exp(input logic [31:0] d);
    exp_t e;
    e.dat = d;
    e.due = cyc + 2;
    exp_q.push_back(e);
    $display("push  cyc=%0d exp=%08h due=%0d", cyc, d, e.due);
  endtask

  // Drive one cycle of input, return at the following negedge.
  task automatic step(input logic [31:0] d, input logic wr, input logic hs);
    dat_in = d;
    wr_in  = wr;
    hs_in  = hs;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b0);
  endtask

  // Output monitor: every DE_OUT pulse must match the oldest queued expectation on time.
  always @(negedge clk) begin
    if (de_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_de", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("out   cyc=%0d dat=%08h exp=%08h", cyc, dat_out, mon_e.dat);
        chk("dat_out", dat_out, mon_e.dat);
        chk("de_latency", cyc, mon_e.due);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      chk("missing_de", 0, 1);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    logic [31:0] a, b, a2, b2;
    @(negedge clk);

    // Reset held with activity on the inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(32'h11223344 + i, i[0], ~i[0]);
      chk("rst_hs_out", hs_out, 0);
      chk("rst_de_out", de_out, 0);
      chk("rst_dat_out", dat_out, 0);
    end
    rst_n = 1'b1;
    idle(3);

    // Basic pair.
    step(32'h40302010, 1'b1, 1'b0);
    push_exp(32'h00FF3818);
    step(32'h0100FFFF, 1'b1, 1'b0);
    idle(4);
    chk("dat_hold", dat_out, 32'h00FF3818);
    chk("de_idle", de_out, 0);

    // Gapped pair.
    step(32'h40302010, 1'b1, 1'b0);
    idle(5);
    push_exp(32'h00FF3818);
    step(32'h0100FFFF, 1'b1, 1'b0);
    idle(4);

    // Odd line: trailing A dropped by HS rise, HS_OUT two cycles late.
    step(32'h07050301, 1'b1, 1'b0);
    chk("hs_out_low", hs_out, 0);
    step(32'h0, 1'b0, 1'b1);
    chk("hs_out_d1", hs_out, 0);
    step(32'h08060402, 1'b1, 1'b1);
    chk("hs_out_d2", hs_out, 1);
    push_exp(32'h00000703);
    step(32'h00000000, 1'b1, 1'b1);
    step(32'h0, 1'b0, 1'b0);
    chk("hs_out_hold", hs_out, 1);
    step(32'h0, 1'b0, 1'b0);
    chk("hs_out_fall", hs_out, 0);
    idle(2);

    // Coincident HS rise and WR with A held: new word is word A.
    a  = 32'h80FF7F01;
    a2 = 32'h12345678;
    b2 = 32'h9ABCDEF0;
    step(a, 1'b1, 1'b0);
    step(a2, 1'b1, 1'b1);
    push_exp(avg_word(a2, b2));
    step(b2, 1'b1, 1'b0);
    idle(4);

    // Run dropped after word A: pair aborted, WR ignored while idle.
    step(32'hAAAAAAAA, 1'b1, 1'b0);
    run = 1'b0;
    step(32'hDEADBEEF, 1'b1, 1'b0);
    step(32'hCAFEF00D, 1'b1, 1'b0);
    run = 1'b1;
    idle(1);
    a2 = 32'h01FE02FD;
    b2 = 32'h10203040;
    step(a2, 1'b1, 1'b0);
    push_exp(avg_word(a2, b2));
    step(b2, 1'b1, 1'b0);
    idle(3);

    // Run dropped right after word B: pair in flight still completes.
    a = 32'h55667788;
    b = 32'hFEFDFCFB;
    step(a, 1'b1, 1'b0);
    push_exp(avg_word(a, b));
    step(b, 1'b1, 1'b0);
    run = 1'b0;
    idle(4);
    run = 1'b1;
    idle(1);

    // Reset mid-pair: no output; following word is a fresh word A.
    step(32'h11111111, 1'b1, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    step(32'h22222222, 1'b1, 1'b0);
    idle(4);
    chk("rst_pair_de", de_out, 0);
    // HS rise clears the held word before the next line.
    step(32'h0, 1'b0, 1'b1);
    idle(3);

    // Back-to-back random pairs.
    for (int k = 0; k < 6; k++) begin
      a = $urandom;
      b = $urandom;
      step(a, 1'b1, 1'b0);
      push_exp(avg_word(a, b));
      step(b, 1'b1, 1'b0);
    end
    idle(6);

    chk("queue_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
